// File: rtl/pipe_stage_skid.sv
// Pipeline register with valid/ready handshake and a 2-entry skid buffer.
// in_ready_o is registered, so downstream stalls never reach upstream combinationally.
module pipe_stage_skid #(
  parameter int               WIDTH      = 70,
  parameter logic [WIDTH-1:0] RESET_DATA = {WIDTH{1'b0}}
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       count_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q;
  logic             in_fire;
  logic             out_fire;

  assign out_valid_o = (state_q != EMPTY);
  assign in_ready_o  = in_ready_q;
  assign out_data_o  = main_q;
  assign in_fire     = in_valid_i & in_ready_q;
  assign out_fire    = out_valid_o & out_ready_i;

  always_comb begin
    count_o = 2'd0;
    unique case (state_q)
      BUSY:    count_o = 2'd1;
      FULL:    count_o = 2'd2;
      default: count_o = 2'd0;
    endcase
  end

  // NOTE: every always_comb output gets a default first, so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      // Flush wins: an incoming beat is consumed and dropped; an outgoing one was delivered.
      state_d = EMPTY;
      main_d  = RESET_DATA;
      skid_d  = RESET_DATA;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data_i;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
          end else if (in_fire) begin
            skid_d  = in_data_i;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= EMPTY;
      main_q     <= RESET_DATA;
      skid_q     <= RESET_DATA;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != FULL);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomised scoreboard bench for pipe_stage_skid (WIDTH=8): a queue models the
// held beats; a negedge monitor checks occupancy/handshake and pops delivered data.
module tb_pipe_stage_skid;

  localparam int W = 8;

  logic         clk_i       = 1'b0;
  logic         rst_i       = 1'b1;
  logic         flush_i     = 1'b0;
  logic         in_valid_i  = 1'b0;
  logic         out_ready_i = 1'b0;
  logic [W-1:0] in_data_i   = '0;
  logic         in_ready_o;
  logic         out_valid_o;
  logic [W-1:0] out_data_o;
  logic [1:0]   count_o;

  pipe_stage_skid #(.WIDTH(W)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .count_o    (count_o)
  );

  always #5 clk_i = ~clk_i;

  logic [W-1:0] exp_q[$];
  bit           mon_en     = 1'b0;
  bit           pend_in    = 1'b0;
  bit           pend_flush = 1'b0;
  logic [W-1:0] pend_data  = '0;
  int           n_checks   = 0;
  int           n_fail     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the block holds a FIFO of at most two beats; ready means fewer than two.
  task automatic decide();
    pend_in    = in_valid_i && (exp_q.size() < 2);
    pend_data  = in_data_i;
    pend_flush = flush_i;
  endtask

  task automatic apply();
    if (pend_flush) exp_q.delete();
    else if (pend_in) exp_q.push_back(pend_data);
    pend_in    = 1'b0;
    pend_flush = 1'b0;
  endtask

  task automatic cycle(input bit v, input logic [W-1:0] d, input bit r, input bit f);
    @(posedge clk_i);
    #1;
    apply();
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = r;
    flush_i     = f;
    decide();
  endtask

  always @(negedge clk_i) begin
    if (mon_en) begin
      check("count", 32'(count_o), 32'(exp_q.size()));
      check("out_valid", 32'(out_valid_o), 32'(exp_q.size() != 0));
      check("in_ready", 32'(in_ready_o), 32'(exp_q.size() < 2));
      if (exp_q.size() != 0) begin
        check("out_data", 32'(out_data_o), 32'(exp_q[0]));
        if (out_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    // Reset with a beat offered upstream: nothing may be accepted.
    in_valid_i  = 1'b1;
    in_data_i   = 8'h3F;
    out_ready_i = 1'b1;
    #1 rst_i = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid_o), 32'd0);
    check("rst_ready", 32'(in_ready_o), 32'd1);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_data", 32'(out_data_o), 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_hold_valid", 32'(out_valid_o), 32'd0);
    rst_i  = 1'b1;
    mon_en = 1'b1;
    decide();
    check("post_rst_count", 32'(count_o), 32'd0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("first_accept_valid", 32'(out_valid_o), 32'd1);
    check("first_accept_data", 32'(out_data_o), 32'h3F);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Streaming at one beat per cycle.
    for (int k = 1; k <= 5; k++) begin
      cycle(k <= 4, W'(k), 1'b1, 1'b0);
      if (k >= 2) begin
        check("stream_data", 32'(out_data_o), 32'(k - 1));
        check("stream_count", 32'(count_o), 32'd1);
        check("stream_ready", 32'(in_ready_o), 32'd1);
      end
    end
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Backpressure: A=5, B=6 held, then drained in order.
    cycle(1'b1, 8'd5, 1'b0, 1'b0);
    cycle(1'b1, 8'd6, 1'b0, 1'b0);
    check("bp_count1", 32'(count_o), 32'd1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("bp_count2", 32'(count_o), 32'd2);
    check("bp_ready", 32'(in_ready_o), 32'd0);
    check("bp_data", 32'(out_data_o), 32'd5);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("bp_hold", 32'(out_data_o), 32'd5);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("bp_second", 32'(out_data_o), 32'd6);
    check("bp_ready_back", 32'(in_ready_o), 32'd1);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Flush while FULL with a beat offered.
    cycle(1'b1, 8'd10, 1'b0, 1'b0);
    cycle(1'b1, 8'd11, 1'b0, 1'b0);
    cycle(1'b1, 8'd9, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("flush_count", 32'(count_o), 32'd0);
    check("flush_valid", 32'(out_valid_o), 32'd0);
    check("flush_data", 32'(out_data_o), 32'd0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Flush coinciding with delivery of 7.
    cycle(1'b1, 8'd7, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("flush_fire_valid", 32'(out_valid_o), 32'd0);
    check("flush_fire_count", 32'(count_o), 32'd0);

    // Asynchronous reset mid-operation while FULL.
    cycle(1'b1, 8'h21, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("pre_rst_count", 32'(count_o), 32'd2);
    #1;
    mon_en = 1'b0;
    rst_i  = 1'b0;
    #1;
    check("mid_rst_count", 32'(count_o), 32'd0);
    check("mid_rst_valid", 32'(out_valid_o), 32'd0);
    check("mid_rst_ready", 32'(in_ready_o), 32'd1);
    check("mid_rst_data", 32'(out_data_o), 32'd0);
    exp_q.delete();
    pend_in    = 1'b0;
    pend_flush = 1'b0;
    #1;
    rst_i  = 1'b1;
    mon_en = 1'b1;

    // Random traffic with occasional flushes and varying downstream pressure.
    for (int i = 0; i < 10000; i++) begin
      int rdy_pct;
      rdy_pct = ((i / 500) % 2 == 0) ? 80 : 30;
      cycle($urandom_range(0, 99) < 60, W'($urandom),
            $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 99) < 3);
    end
    repeat (4) cycle(1'b0, '0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
